// File: rtl/ps2_key_decoder_if.sv
// PS/2 keyboard pins plus the decoded key outputs that the controller and
// datapath consume. The master side owns the PS/2 lines (keyboard or bench),
// the slave side is the decoder.
interface ps2_key_decoder_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [4:0] direction;
  logic [4:0] number;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_error;

  modport master (
    output PS2_CLK,
    output PS2_DAT,
    input  direction,
    input  number,
    input  scan_code,
    input  code_valid,
    input  frame_error
  );

  modport slave (
    input  PS2_CLK,
    input  PS2_DAT,
    output direction,
    output number,
    output scan_code,
    output code_valid,
    output frame_error
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and key decoder clocked by the system clock.
// The raw PS/2 pins are synchronised, 11-bit frames are assembled on falling
// edges of the synchronised PS/2 clock, and good bytes drive prefix tracking
// (E0 / F0) and the held direction / number codes.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  ps2_key_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  // Odd parity check over the 8 data bits plus the received parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Arrow make codes map to a one-hot direction; anything else means "none".
  function automatic logic [4:0] dir_decode(input logic [7:0] code);
    logic [4:0] dir;
    case (code)
      8'h75:   dir = 5'b00010;
      8'h6B:   dir = 5'b00100;
      8'h72:   dir = 5'b01000;
      8'h74:   dir = 5'b10000;
      default: dir = 5'b00000;
    endcase
    return dir;
  endfunction

  // Released digit keys 1/2/3 select the difficulty; anything else clears it.
  function automatic logic [4:0] num_decode(input logic [7:0] code);
    logic [4:0] num;
    case (code)
      8'h16:   num = 5'b00010;
      8'h1E:   num = 5'b00100;
      8'h26:   num = 5'b01000;
      default: num = 5'b00000;
    endcase
    return num;
  endfunction

  logic            ps2_clk_meta_r;
  logic            ps2_clk_sync_r;
  logic            ps2_clk_prev_r;
  logic            ps2_dat_meta_r;
  logic            ps2_dat_sync_r;
  logic            fall_s;

  rx_state_t       state_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shift_r;
  logic            parity_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            ext_pend_r;
  logic            brk_pend_r;

  logic [4:0]      direction_r;
  logic [4:0]      number_r;
  logic [7:0]      scan_code_r;
  logic            code_valid_r;
  logic            frame_error_r;

  // Two-flop synchronisers; reset to 1 so an idle bus never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2_clk_meta_r <= 1'b1;
      ps2_clk_sync_r <= 1'b1;
      ps2_clk_prev_r <= 1'b1;
      ps2_dat_meta_r <= 1'b1;
      ps2_dat_sync_r <= 1'b1;
    end else begin
      ps2_clk_meta_r <= bus.PS2_CLK;
      ps2_clk_sync_r <= ps2_clk_meta_r;
      ps2_clk_prev_r <= ps2_clk_sync_r;
      ps2_dat_meta_r <= bus.PS2_DAT;
      ps2_dat_sync_r <= ps2_dat_meta_r;
    end
  end

  assign fall_s = ps2_clk_prev_r & ~ps2_clk_sync_r;

  // Frame receiver, timeout supervision, prefix tracking and key decoding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      parity_r      <= 1'b0;
      to_cnt_r      <= '0;
      ext_pend_r    <= 1'b0;
      brk_pend_r    <= 1'b0;
      direction_r   <= 5'b00000;
      number_r      <= 5'b00000;
      scan_code_r   <= 8'h00;
      code_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      code_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      if (fall_s) begin
        // An edge always restarts the timeout, even when it coincides with expiry.
        to_cnt_r <= '0;
        case (state_r)
          ST_IDLE: begin
            if (!ps2_dat_sync_r) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              state_r   <= ST_IDLE;
            end
          end
          ST_DATA: begin
            shift_r <= {ps2_dat_sync_r, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          ST_PARITY: begin
            parity_r <= ps2_dat_sync_r;
            state_r  <= ST_STOP;
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
            if (ps2_dat_sync_r && odd_parity_ok(shift_r, parity_r)) begin
              code_valid_r <= 1'b1;
              scan_code_r  <= shift_r;
              if (shift_r == 8'hE0) begin
                ext_pend_r <= 1'b1;
              end else if (shift_r == 8'hF0) begin
                brk_pend_r <= 1'b1;
                ext_pend_r <= ext_pend_r;
              end else begin
                if (brk_pend_r) begin
                  number_r <= num_decode(shift_r);
                end else begin
                  direction_r <= dir_decode(shift_r);
                end
                ext_pend_r <= 1'b0;
                brk_pend_r <= 1'b0;
              end
            end else begin
              frame_error_r <= 1'b1;
              ext_pend_r    <= 1'b0;
              brk_pend_r    <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end else if (state_r == ST_IDLE) begin
        to_cnt_r <= '0;
      end else if (to_cnt_r == TO_LIMIT) begin
        // Stalled partial frame: abandon it and forget any pending prefix.
        state_r       <= ST_IDLE;
        to_cnt_r      <= '0;
        frame_error_r <= 1'b1;
        ext_pend_r    <= 1'b0;
        brk_pend_r    <= 1'b0;
      end else begin
        to_cnt_r <= to_cnt_r + TO_ONE;
      end
    end
  end

  assign bus.direction   = direction_r;
  assign bus.number      = number_r;
  assign bus.scan_code   = scan_code_r;
  assign bus.code_valid  = code_valid_r;
  assign bus.frame_error = frame_error_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames bit by bit, pushes
// the expected scan/direction/number for each good frame into a scoreboard
// and compares on every code_valid pulse.
module tb_ps2_key_decoder;

  localparam int TO   = 300;
  localparam int HALF = 20;

  logic clk;
  logic reset_n;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .TIMEOUT_CYCLES (TO),
    .TO_W           (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0] scan;
    logic [4:0] dir;
    logic [4:0] num;
  } exp_t;

  exp_t exp_q[$];

  int vectors    = 0;
  int miscompares = 0;
  int cv_cnt     = 0;
  int fe_cnt     = 0;
  logic prev_cv  = 1'b0;
  logic prev_fe  = 1'b0;

  logic [4:0] m_dir = 5'b00000;
  logic [4:0] m_num = 5'b00000;
  logic       m_brk = 1'b0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare every code_valid pulse against the queue head.
  always @(negedge clk) begin
    if (bus.code_valid === 1'b1) begin
      cv_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_unexpected: observed code_valid with scan %0h expected no pulse", bus.scan_code);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_scan", 16'(bus.scan_code), 16'(e.scan));
        check("sb_dir",  16'(bus.direction), 16'(e.dir));
        check("sb_num",  16'(bus.number),    16'(e.num));
        check("cv_fe_excl", 16'(bus.frame_error), 16'd0);
        check("cv_width", 16'(prev_cv), 16'd0);
      end
    end
    if (bus.frame_error === 1'b1) begin
      fe_cnt++;
      check("fe_width", 16'(prev_fe), 16'd0);
    end
    prev_cv = bus.code_valid;
    prev_fe = bus.frame_error;
  end

  // Reference behaviour of one good byte, pushed before the frame is sent.
  task automatic model_good(input logic [7:0] b);
    exp_t e;
    if (b == 8'hE0) begin
      // prefix only
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (m_brk) begin
      case (b)
        8'h16:   m_num = 5'b00010;
        8'h1E:   m_num = 5'b00100;
        8'h26:   m_num = 5'b01000;
        default: m_num = 5'b00000;
      endcase
      m_brk = 1'b0;
    end else begin
      case (b)
        8'h75:   m_dir = 5'b00010;
        8'h6B:   m_dir = 5'b00100;
        8'h72:   m_dir = 5'b01000;
        8'h74:   m_dir = 5'b10000;
        default: m_dir = 5'b00000;
      endcase
    end
    e.scan = b;
    e.dir  = m_dir;
    e.num  = m_num;
    exp_q.push_back(e);
  endtask

  task automatic pulse_bit(input logic b);
    repeat (HALF) @(posedge clk);
    #2 bus.PS2_DAT = b;
    repeat (HALF) @(posedge clk);
    #2 bus.PS2_CLK = 1'b0;
    repeat (HALF) @(posedge clk);
    #2 bus.PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    int cv0;
    int fe0;
    logic par;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    par = ~(^b);
    if (bad_par) begin
      par   = ~par;
      m_brk = 1'b0;
    end else begin
      model_good(b);
    end
    pulse_bit(1'b0);
    for (int i = 0; i < 8; i++) pulse_bit(b[i]);
    pulse_bit(par);
    pulse_bit(1'b1);
    repeat (10) @(posedge clk);
    #2;
    check("cv_delta", 16'(cv_cnt - cv0), bad_par ? 16'd0 : 16'd1);
    check("fe_delta", 16'(fe_cnt - fe0), bad_par ? 16'd1 : 16'd0);
  endtask

  initial begin
    int cv0;
    int fe0;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    reset_n     = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dir",  16'(bus.direction),   16'd0);
    check("rst_num",  16'(bus.number),      16'd0);
    check("rst_scan", 16'(bus.scan_code),   16'd0);
    check("rst_cv",   16'(bus.code_valid),  16'd0);
    check("rst_fe",   16'(bus.frame_error), 16'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Up-arrow with extended prefix.
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("up_dir", 16'(bus.direction), 16'h0002);
    check("up_num", 16'(bus.number),    16'h0000);

    // Key "2" press and release.
    send_frame(8'h1E, 1'b0);
    check("k2_make_dir", 16'(bus.direction), 16'h0000);
    send_frame(8'hF0, 1'b0);
    check("k2_f0_num", 16'(bus.number), 16'h0000);
    send_frame(8'h1E, 1'b0);
    check("k2_brk_num", 16'(bus.number),    16'h0004);
    check("k2_brk_dir", 16'(bus.direction), 16'h0000);

    // Right arrow, its extended release, then another key.
    send_frame(8'h74, 1'b0);
    check("right_dir", 16'(bus.direction), 16'h0010);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h74, 1'b0);
    check("right_rel_dir", 16'(bus.direction), 16'h0010);
    send_frame(8'h1C, 1'b0);
    check("other_dir", 16'(bus.direction), 16'h0000);

    // Parity error, then a good left arrow.
    send_frame(8'h75, 1'b1);
    check("par_dir", 16'(bus.direction), 16'h0000);
    send_frame(8'h6B, 1'b0);
    check("left_dir", 16'(bus.direction), 16'h0004);

    // Timeout on a stalled partial frame.
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    pulse_bit(1'b0);
    for (int i = 0; i < 4; i++) pulse_bit(1'b1);
    repeat (TO + 10) @(posedge clk);
    #2;
    m_brk = 1'b0;
    check("to_fe_delta", 16'(fe_cnt - fe0), 16'd1);
    check("to_cv_delta", 16'(cv_cnt - cv0), 16'd0);
    check("to_dir", 16'(bus.direction), 16'h0004);
    send_frame(8'h72, 1'b0);
    check("down_dir", 16'(bus.direction), 16'h0008);

    // Async reset mid-frame.
    send_frame(8'hF0, 1'b0);
    send_frame(8'h26, 1'b0);
    send_frame(8'h75, 1'b0);
    check("pre_rst_dir", 16'(bus.direction), 16'h0002);
    check("pre_rst_num", 16'(bus.number),    16'h0008);
    fe0 = fe_cnt;
    pulse_bit(1'b0);
    pulse_bit(1'b1);
    pulse_bit(1'b0);
    @(posedge clk);
    #5 reset_n = 1'b0;
    #1;
    check("arst_dir",  16'(bus.direction),   16'd0);
    check("arst_num",  16'(bus.number),      16'd0);
    check("arst_scan", 16'(bus.scan_code),   16'd0);
    check("arst_cv",   16'(bus.code_valid),  16'd0);
    check("arst_fe",   16'(bus.frame_error), 16'd0);
    m_dir = 5'b00000;
    m_num = 5'b00000;
    m_brk = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h74, 1'b0);
    check("post_rst_dir", 16'(bus.direction), 16'h0010);
    check("post_rst_num", 16'(bus.number),    16'h0000);
    check("rst_no_fe", 16'(fe_cnt - fe0), 16'd0);

    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
